// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the five-stage pipeline controller.
// Holds the FSM encoding, enable/flush bundles and the wait-counter sizing helper.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 255;

  // Bit order matches pipeline order: PC first, MEM/WB last.
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } en_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
  } flush_t;

  // Width needed to hold 0..timeout inclusive.
  function automatic int wait_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Counts on each enabled cycle and holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: RUN, MEM_WAIT and HALT states drive the
// PC and pipeline-register enables and flushes (Mealy), with perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output state_t           fsm_state
);

  localparam int WAIT_W = wait_w(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;
  logic              timeout_hit;
  en_t               en;
  flush_t            flush;

  assign mem_stall   = mem_req && !mem_ack;
  assign timeout_hit = (state == ST_MEM_WAIT) && !mem_ack && (wait_cnt == WAIT_MAX);

  // Normal-flow response shared by RUN and the MEM_WAIT ack cycle.
  function automatic logic [6:0] run_resp(input logic bt, input logic lu);
    en_t    e;
    flush_t f;
    e = '1;
    f = '0;
    if (bt) begin
      f = '1;
    end else if (lu) begin
      e.pc    = 1'b0;
      e.if_id = 1'b0;
      f.id_ex = 1'b1;
    end
    return {e, f};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      ST_RUN: begin
        if (halt_req)       next_state = ST_HALT;
        else if (mem_stall) next_state = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (mem_ack)          next_state = ST_RUN;
        else if (timeout_hit) next_state = ST_HALT;
      end
      ST_HALT: begin
        if (resume) next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  // Output logic; everything is forced low while reset is held.
  always_comb begin
    en    = '0;
    flush = '0;
    unique case (state)
      ST_RUN: begin
        if (halt_req) begin
          en.mem_wb = 1'b1;
        end else if (!mem_stall) begin
          {en, flush} = run_resp(branch_taken, load_use);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          {en, flush} = run_resp(branch_taken, load_use);
        end
      end
      ST_HALT: begin
        en    = '0;
        flush = '0;
      end
      default: begin
        en    = '0;
        flush = '0;
      end
    endcase
    if (!rst_n) begin
      en    = '0;
      flush = '0;
    end
  end

  // Wait counter saturates at TIMEOUT so it can never wrap back under it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if ((state == ST_RUN) && (next_state == ST_MEM_WAIT)) begin
      wait_cnt <= '0;
    end else if ((state == ST_MEM_WAIT) && !mem_ack && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err <= 1'b0;
    end else if (timeout_hit) begin
      mem_err <= 1'b1;
    end
  end

  assign pc_en       = en.pc;
  assign if_id_en    = en.if_id;
  assign id_ex_en    = en.id_ex;
  assign ex_mem_en   = en.ex_mem;
  assign mem_wb_en   = en.mem_wb;
  assign if_id_flush = flush.if_id;
  assign id_ex_flush = flush.id_ex;
  assign halted      = rst_n && (state == ST_HALT);
  assign fsm_state   = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!en.pc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush.if_id),
    .count (flush_cnt)
  );

endmodule
